glitch_sequencer: RTL and testbench

Clock-domain controller that sequences one glitch attempt around the asynchronous event counter. On arm, it clears and enables the counter with a latched threshold, and synchronizes the counter's trigger into `clk_i`. After the trigger, it waits a programmable delay and drives a glitch pulse of programmable width. It sits between the host register file and the event counter / glitch output driver.

---
 rtl/glitch_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_glitch_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - sequences one glitch attempt: arm, flush, trigger sync, delay, pulse
// Optional multi-shot mode with per-shot delay stepping is enabled by GLITCH_SEQ_REPEAT_EN.
module glitch_sequencer #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] threshold_i,
  input  logic [WIDTH-1:0] delay_i,
  input  logic [WIDTH-1:0] width_i,
`ifdef GLITCH_SEQ_REPEAT_EN
  input  logic [7:0]       repeat_i,
  input  logic [WIDTH-1:0] step_i,
  output logic [7:0]       shot_o,
`endif
  input  logic             ec_trigger_i,
  output logic             ec_rst_o,
  output logic             ec_enable_o,
  output logic [WIDTH-1:0] ec_threshold_o,
  output logic             glitch_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [2:0]       state_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CLEAR     = 3'd1;
  localparam logic [2:0] WAIT_TRIG = 3'd2;
  localparam logic [2:0] DELAY     = 3'd3;
  localparam logic [2:0] PULSE     = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] CLR_LEN = WIDTH'(SYNC_STAGES + 1);

  logic [2:0]             state_q, state_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       thr_q, thr_d;
  logic [WIDTH-1:0]       dly_q, dly_d;
  logic [WIDTH-1:0]       wid_q, wid_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   glitch_q;
  logic                   ec_rst_q;
  logic                   ec_en_q;
  logic                   trig_sync;

`ifdef GLITCH_SEQ_REPEAT_EN
  logic [7:0]       rep_q, rep_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [7:0]       shot_q, shot_d;
`endif

  assign trig_sync = sync_q[SYNC_STAGES-1];

  // One shared down-counter times CLEAR, DELAY and PULSE; every phase ends when it reads 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    thr_d   = thr_q;
    dly_d   = dly_q;
    wid_d   = wid_q;
`ifdef GLITCH_SEQ_REPEAT_EN
    rep_d   = rep_q;
    step_d  = step_q;
    shot_d  = shot_q;
`endif
    if (state_q != IDLE && abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm_i && !abort_i) begin
            thr_d   = (threshold_i == '0) ? ONE : threshold_i;
            dly_d   = delay_i;
            wid_d   = (width_i == '0) ? ONE : width_i;
            cnt_d   = CLR_LEN;
            state_d = CLEAR;
`ifdef GLITCH_SEQ_REPEAT_EN
            rep_d   = repeat_i;
            step_d  = step_i;
            shot_d  = 8'd0;
`endif
          end
        end
        CLEAR: begin
          if (cnt_q == ONE) state_d = WAIT_TRIG;
          else              cnt_d   = cnt_q - ONE;
        end
        WAIT_TRIG: begin
          if (trig_sync) begin
            if (dly_q == '0) begin
              state_d = PULSE;
              cnt_d   = wid_q;
            end else begin
              state_d = DELAY;
              cnt_d   = dly_q;
            end
          end
        end
        DELAY: begin
          if (cnt_q == ONE) begin
            state_d = PULSE;
            cnt_d   = wid_q;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        PULSE: begin
          if (cnt_q == ONE) begin
`ifdef GLITCH_SEQ_REPEAT_EN
            shot_d = shot_q + 8'd1;
            // shot_q shots done before this one; another follows while shot_q < repeat
            if (shot_q < rep_q) begin
              state_d = CLEAR;
              cnt_d   = CLR_LEN;
              dly_d   = dly_q + step_q;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      thr_q    <= ONE;
      dly_q    <= '0;
      wid_q    <= ONE;
      sync_q   <= '0;
      glitch_q <= 1'b0;
      ec_rst_q <= 1'b1;
      ec_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      thr_q    <= thr_d;
      dly_q    <= dly_d;
      wid_q    <= wid_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], ec_trigger_i};
      glitch_q <= (state_d == PULSE);
      ec_rst_q <= (state_d == IDLE) || (state_d == CLEAR);
      ec_en_q  <= (state_d == WAIT_TRIG);
    end
  end

`ifdef GLITCH_SEQ_REPEAT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rep_q  <= 8'd0;
      step_q <= '0;
      shot_q <= 8'd0;
    end else begin
      rep_q  <= rep_d;
      step_q <= step_d;
      shot_q <= shot_d;
    end
  end

  assign shot_o = shot_q;
`endif

  assign ec_rst_o       = ec_rst_q;
  assign ec_enable_o    = ec_en_q;
  assign ec_threshold_o = thr_q;
  assign glitch_o       = glitch_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign state_o        = state_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb/tb_glitch_sequencer.sv - randomized self-checking bench for glitch_sequencer
// Includes a behavioural event counter; repeat-mode scenario runs when GLITCH_SEQ_REPEAT_EN is defined.
module tb_glitch_sequencer;
  localparam int W = 32;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         arm = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] thr_i = '0;
  logic [W-1:0] dly_i = '0;
  logic [W-1:0] wid_i = '0;
`ifdef GLITCH_SEQ_REPEAT_EN
  logic [7:0]   rep_i = '0;
  logic [W-1:0] step_i = '0;
  logic [7:0]   shot;
`endif
  logic         ec_trig, ec_rst, ec_en, glitch, busy, done;
  logic [W-1:0] ec_thr;
  logic [2:0]   state;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  // Event counter model: counts events while enabled, cleared while ec_rst is high
  logic         ev = 1'b0;
  logic         stale = 1'b0;
  logic [W-1:0] ev_cnt = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge ev or posedge ec_rst) begin
    if (ec_rst) ev_cnt <= '0;
    else if (ec_en) ev_cnt <= ev_cnt + 1;
  end
  assign ec_trig = stale | (ev_cnt >= ec_thr);

  glitch_sequencer #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .rst_i(rst_i), .arm_i(arm), .abort_i(abort),
    .threshold_i(thr_i), .delay_i(dly_i), .width_i(wid_i),
`ifdef GLITCH_SEQ_REPEAT_EN
    .repeat_i(rep_i), .step_i(step_i), .shot_o(shot),
`endif
    .ec_trigger_i(ec_trig), .ec_rst_o(ec_rst), .ec_enable_o(ec_en),
    .ec_threshold_o(ec_thr), .glitch_o(glitch), .busy_o(busy),
    .done_o(done), .state_o(state)
  );

  int arm_cyc, en_cyc, done_n, done_c, busy_fall, en_bad, thr_bad, rearm_bad;
  bit timeout;
  int r_q[$], rise_q[$], len_q[$];
  logic ab_glitch, ab_rst, rs_glitch, rs_rst, rs_en, rs_busy, rs_done;
  logic [2:0] ab_state, rs_state;
  logic [W-1:0] rs_thr;

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Drives one armed run and records the observed timeline (cycle = edge count at sampling)
  task automatic do_run(input logic [W-1:0] thr, input logic [W-1:0] d, input logic [W-1:0] w,
                        input int abort_at, input int arm_st, input int rst_st, input bit stale_pre);
    logic [W-1:0] exp_thr;
    logic g_prev;
    int cur_len, c;
    bit trig_seen, arm_done, rst_done;
    exp_thr = (thr == '0) ? 1 : thr;
    g_prev = 1'b0; cur_len = 0; trig_seen = 0; arm_done = 0; rst_done = 0;
    r_q.delete(); rise_q.delete(); len_q.delete();
    en_cyc = -1; done_n = 0; done_c = -1; busy_fall = -1; en_bad = 0; thr_bad = 0;
    rearm_bad = 0; timeout = 1;
    thr_i = thr; dly_i = d; wid_i = w; stale = stale_pre;
    @(negedge clk);
    arm = 1'b1; arm_cyc = cyc + 1;
    @(negedge clk);
    arm = 1'b0; stale = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      c = cyc;
      if (abort) begin
        abort = 1'b0; ab_glitch = glitch; ab_state = state; ab_rst = ec_rst;
      end
      if (arm) arm = 1'b0;
      if (glitch && !g_prev) begin rise_q.push_back(c); cur_len = 0; end
      if (glitch) cur_len++;
      if (!glitch && g_prev) len_q.push_back(cur_len);
      g_prev = glitch;
      if (done) begin done_n++; done_c = c; end
      if (!busy) begin busy_fall = c; timeout = 0; break; end
      if (ec_en && en_cyc < 0) en_cyc = c;
      if ((state == 3'd2) != ec_en) en_bad++;
      if (ec_thr !== exp_thr) thr_bad++;
      if (!ec_en) trig_seen = 0;
      if (abort_at > 0 && glitch && cur_len == abort_at) abort = 1'b1;
      if (int'(state) == arm_st && !arm_done) begin
        arm = 1'b1; arm_done = 1; thr_i = thr + 7; dly_i = d + 9; wid_i = w + 2;
      end
      if (int'(state) == rst_st && !rst_done) begin
        rst_done = 1;
        #2 rst_i = 1'b1;
        #1 begin
          rs_glitch = glitch; rs_rst = ec_rst; rs_en = ec_en; rs_busy = busy;
          rs_done = done; rs_state = state; rs_thr = ec_thr;
        end
        #1 rst_i = 1'b0;
      end
      if (ec_en && (c % 2 == 0)) begin ev = 1'b1; #1; ev = 1'b0; end
      if (ec_en && ec_trig && !trig_seen) begin r_q.push_back(c + 1); trig_seen = 1; end
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy) rearm_bad++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_total++; if (ec_rst !== 1'b1) $display("FAIL reset_ec_rst: got %0b expected 1", ec_rst); else n_pass++;
    n_total++; if (ec_en !== 1'b0) $display("FAIL reset_ec_en: got %0b expected 0", ec_en); else n_pass++;
    n_total++; if (glitch !== 1'b0) $display("FAIL reset_glitch: got %0b expected 0", glitch); else n_pass++;
    n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got %0b%0b expected 00", busy, done); else n_pass++;
    n_total++; if (ec_thr !== 32'd1) $display("FAIL reset_thr: got %0d expected 1", ec_thr); else n_pass++;
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state); else n_pass++;
  endtask

  task automatic test_basic;
    do_run(3, 5, 2, 0, -1, -1, 0);
    n_total++; if (timeout) $display("FAIL basic_timeout: got timeout expected run end"); else n_pass++;
    n_total++; if (en_cyc !== arm_cyc + S + 1) $display("FAIL basic_enable_rise: got %0d expected %0d", en_cyc, arm_cyc + S + 1); else n_pass++;
    n_total++; if (qget(rise_q, 0) !== qget(r_q, 0) + S + 5) $display("FAIL basic_glitch_rise: got %0d expected %0d", qget(rise_q, 0), qget(r_q, 0) + S + 5); else n_pass++;
    n_total++; if (qget(len_q, 0) !== 2) $display("FAIL basic_glitch_len: got %0d expected 2", qget(len_q, 0)); else n_pass++;
    n_total++; if (done_n !== 1 || done_c !== qget(rise_q, 0) + 2) $display("FAIL basic_done: got n=%0d at %0d expected n=1 at %0d", done_n, done_c, qget(rise_q, 0) + 2); else n_pass++;
    n_total++; if (busy_fall !== done_c + 1) $display("FAIL basic_busy_fall: got %0d expected %0d", busy_fall, done_c + 1); else n_pass++;
    n_total++; if (en_bad !== 0) $display("FAIL basic_enable_only_wait: got %0d bad cycles expected 0", en_bad); else n_pass++;
    n_total++; if (thr_bad !== 0) $display("FAIL basic_thr_stable: got %0d bad cycles expected 0", thr_bad); else n_pass++;
  endtask

  task automatic test_zero_clamps;
    do_run(0, 0, 0, 0, -1, -1, 0);
    n_total++; if (qget(rise_q, 0) !== qget(r_q, 0) + S) $display("FAIL zero_glitch_rise: got %0d expected %0d", qget(rise_q, 0), qget(r_q, 0) + S); else n_pass++;
    n_total++; if (qget(len_q, 0) !== 1) $display("FAIL zero_width_clamp: got %0d expected 1", qget(len_q, 0)); else n_pass++;
    n_total++; if (thr_bad !== 0) $display("FAIL zero_thr_clamp: got %0d bad cycles expected 0", thr_bad); else n_pass++;
    n_total++; if (done_n !== 1) $display("FAIL zero_done: got %0d expected 1", done_n); else n_pass++;
  endtask

  task automatic test_abort;
    do_run(2, 3, 10, 4, -1, -1, 0);
    n_total++; if (ab_glitch !== 1'b0) $display("FAIL abort_glitch: got %0b expected 0", ab_glitch); else n_pass++;
    n_total++; if (ab_state !== 3'd0 || ab_rst !== 1'b1) $display("FAIL abort_idle: got state %0d ec_rst %0b expected 0 1", ab_state, ab_rst); else n_pass++;
    n_total++; if (done_n !== 0) $display("FAIL abort_no_done: got %0d expected 0", done_n); else n_pass++;
    n_total++; if (qget(len_q, 0) !== 4) $display("FAIL abort_pulse_len: got %0d expected 4", qget(len_q, 0)); else n_pass++;
  endtask

  task automatic test_stale;
    do_run(2, 3, 3, 0, -1, -1, 1);
    n_total++; if (rise_q.size() !== 1) $display("FAIL stale_pulse_count: got %0d expected 1", rise_q.size()); else n_pass++;
    n_total++; if (qget(rise_q, 0) !== qget(r_q, 0) + S + 3) $display("FAIL stale_glitch_rise: got %0d expected %0d", qget(rise_q, 0), qget(r_q, 0) + S + 3); else n_pass++;
    n_total++; if (qget(r_q, 0) <= en_cyc) $display("FAIL stale_trigger_after_enable: got %0d expected above %0d", qget(r_q, 0), en_cyc); else n_pass++;
  endtask

  task automatic test_rearm_busy;
    do_run(4, 6, 3, 0, 3, -1, 0);
    n_total++; if (thr_bad !== 0) $display("FAIL rearm_thr_stable: got %0d bad cycles expected 0", thr_bad); else n_pass++;
    n_total++; if (qget(rise_q, 0) !== qget(r_q, 0) + S + 6) $display("FAIL rearm_delay_kept: got %0d expected %0d", qget(rise_q, 0), qget(r_q, 0) + S + 6); else n_pass++;
    n_total++; if (qget(len_q, 0) !== 3) $display("FAIL rearm_width_kept: got %0d expected 3", qget(len_q, 0)); else n_pass++;
    n_total++; if (done_n !== 1 || rearm_bad !== 0) $display("FAIL rearm_not_queued: got done %0d busy-after %0d expected 1 0", done_n, rearm_bad); else n_pass++;
  endtask

  task automatic test_reset_mid;
    for (int st = 3; st <= 4; st++) begin
      do_run(3, 20, 5, 0, -1, st, 0);
      n_total++; if (rs_glitch !== 1'b0 || rs_done !== 1'b0) $display("FAIL rst%0d_glitch_done: got %0b%0b expected 00", st, rs_glitch, rs_done); else n_pass++;
      n_total++; if (rs_rst !== 1'b1 || rs_en !== 1'b0) $display("FAIL rst%0d_ec: got rst %0b en %0b expected 1 0", st, rs_rst, rs_en); else n_pass++;
      n_total++; if (rs_busy !== 1'b0 || rs_state !== 3'd0) $display("FAIL rst%0d_idle: got busy %0b state %0d expected 0 0", st, rs_busy, rs_state); else n_pass++;
      n_total++; if (rs_thr !== 32'd1) $display("FAIL rst%0d_thr: got %0d expected 1", st, rs_thr); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [W-1:0] t, d, w, ew;
    for (int i = 0; i < 6; i++) begin
      t = $urandom_range(0, 4); d = $urandom_range(0, 9); w = $urandom_range(0, 5);
      ew = (w == '0) ? 1 : w;
      do_run(t, d, w, 0, -1, -1, 0);
      n_total++; if (qget(rise_q, 0) !== qget(r_q, 0) + S + int'(d)) $display("FAIL rand%0d_rise: got %0d expected %0d", i, qget(rise_q, 0), qget(r_q, 0) + S + int'(d)); else n_pass++;
      n_total++; if (qget(len_q, 0) !== int'(ew)) $display("FAIL rand%0d_len: got %0d expected %0d", i, qget(len_q, 0), ew); else n_pass++;
      n_total++; if (done_n !== 1 || busy_fall !== qget(rise_q, 0) + int'(ew) + 1) $display("FAIL rand%0d_done_busy: got n=%0d fall %0d expected n=1 fall %0d", i, done_n, busy_fall, qget(rise_q, 0) + int'(ew) + 1); else n_pass++;
      n_total++; if (en_bad !== 0 || thr_bad !== 0) $display("FAIL rand%0d_enable_thr: got %0d %0d expected 0 0", i, en_bad, thr_bad); else n_pass++;
    end
  endtask

`ifdef GLITCH_SEQ_REPEAT_EN
  task automatic test_repeat;
    rep_i = 8'd2; step_i = 3;
    do_run(2, 4, 2, 0, -1, -1, 0);
    n_total++; if (rise_q.size() !== 3) $display("FAIL repeat_pulse_count: got %0d expected 3", rise_q.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (qget(rise_q, i) !== qget(r_q, i) + S + 4 + 3 * i) $display("FAIL repeat_rise%0d: got %0d expected %0d", i, qget(rise_q, i), qget(r_q, i) + S + 4 + 3 * i); else n_pass++;
    end
    n_total++; if (shot !== 8'd3) $display("FAIL repeat_shots: got %0d expected 3", shot); else n_pass++;
    n_total++; if (done_n !== 1) $display("FAIL repeat_single_done: got %0d expected 1", done_n); else n_pass++;
    rep_i = 8'd0; step_i = '0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_clamps();
    test_abort();
    test_stale();
    test_rearm_busy();
    test_reset_mid();
    test_random();
`ifdef GLITCH_SEQ_REPEAT_EN
    test_repeat();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
